// File: rtl/udp_echo_if.sv
// udp_echo_if: UDP receive/transmit handshake between eth and
// the echo block, plus echo status outputs.
interface udp_echo_if;
  logic        udp_rx_data_vld;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_done;
  logic [15:0] udp_rx_data_num;
  logic        tx_rdy;
  logic        udp_tx_req;
  logic        udp_tx_en;
  logic [15:0] udp_tx_data_num;
  logic [7:0]  udp_tx_data;
  logic        busy;
  logic [15:0] drop_cnt;

  modport master (
    output udp_rx_data_vld,
    output udp_rx_data,
    output udp_rx_done,
    output udp_rx_data_num,
    output tx_rdy,
    output udp_tx_req,
    input  udp_tx_en,
    input  udp_tx_data_num,
    input  udp_tx_data,
    input  busy,
    input  drop_cnt
  );

  modport slave (
    input  udp_rx_data_vld,
    input  udp_rx_data,
    input  udp_rx_done,
    input  udp_rx_data_num,
    input  tx_rdy,
    input  udp_tx_req,
    output udp_tx_en,
    output udp_tx_data_num,
    output udp_tx_data,
    output busy,
    output drop_cnt
  );
endinterface

// File: rtl/udp_echo_ctrl.sv
// udp_echo_ctrl: buffers one UDP datagram and sends the same
// payload back through the eth UDP transmit handshake.
module udp_echo_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1472
) (
  input  logic      clk,
  input  logic      rst,
  udp_echo_if.slave u_if
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;
  localparam logic [15:0] L_MAX = 16'(MAX_LEN);
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]  r_mem [DEPTH];
  logic [1:0]  r_state;
  logic [1:0]  w_nxt;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_ptr;
  logic [15:0] r_tx_num;
  logic [15:0] r_drop;
  logic [7:0]  r_tx_data;
  logic        r_tx_en;
  logic        r_busy;

  logic        w_vld;
  logic        w_done;
  logic        w_rx_st;
  logic        w_we;
  logic        w_re;
  logic        w_ok;
  logic        w_drop;
  logic [15:0] w_base;
  logic [15:0] w_inc;
  logic [15:0] w_fin;

  assign w_vld  = u_if.udp_rx_data_vld;
  assign w_done = u_if.udp_rx_done;

  // IDLE behaves as RECV with an empty count, so a
  // 1-byte datagram completing in IDLE is handled too.
  assign w_rx_st = (r_state == S_IDLE) ||
                   (r_state == S_RECV);
  assign w_base  = (r_state == S_RECV) ? r_wr_cnt
                                       : 16'd0;
  assign w_inc   = (w_base == 16'hFFFF) ? w_base
                                        : w_base + 16'd1;
  assign w_fin   = w_vld ? w_inc : w_base;

  assign w_we = !rst && w_rx_st && w_vld &&
                (w_base < L_MAX);
  assign w_re = (r_state == S_SEND) &&
                u_if.udp_tx_req &&
                (r_rd_ptr < r_tx_num);

  assign w_ok = (w_fin == u_if.udp_rx_data_num) &&
                (w_fin != 16'd0) &&
                (w_fin <= L_MAX);

  // busy states drop every completed datagram
  assign w_drop = w_done && !(w_rx_st && w_ok);

  // next-state decode
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_RECV: begin
        if (w_done)
          w_nxt = w_ok ? S_WAIT : S_IDLE;
        else if (w_vld)
          w_nxt = S_RECV;
      end
      S_WAIT: begin
        if (u_if.tx_rdy)
          w_nxt = S_SEND;
      end
      S_SEND: begin
        if (r_rd_ptr == r_tx_num)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_tx_en   <= 1'b0;
      r_wr_cnt  <= 16'd0;
      r_rd_ptr  <= 16'd0;
      r_tx_num  <= 16'd0;
      r_tx_data <= 8'd0;
      r_drop    <= 16'd0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_tx_en <= (r_state == S_WAIT) && u_if.tx_rdy;

      if (w_rx_st) begin
        if (w_done)
          r_wr_cnt <= 16'd0;
        else if (w_vld)
          r_wr_cnt <= w_inc;
      end

      if (w_rx_st && w_done && w_ok)
        r_tx_num <= w_fin;

      if (r_state == S_WAIT)
        r_rd_ptr <= 16'd0;
      else if (w_re)
        r_rd_ptr <= r_rd_ptr + 16'd1;

      r_tx_data <= w_re ? r_mem[r_rd_ptr[ADDR_W-1:0]]
                        : 8'd0;

      if (w_drop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  // payload buffer write port
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_base[ADDR_W-1:0]] <= u_if.udp_rx_data;
  end

  assign u_if.udp_tx_en       = r_tx_en;
  assign u_if.udp_tx_data_num = r_tx_num;
  assign u_if.udp_tx_data     = r_tx_data;
  assign u_if.busy            = r_busy;
  assign u_if.drop_cnt        = r_drop;
endmodule

// File: tb/tb_udp_echo_ctrl.sv
// tb_udp_echo_ctrl: directed and random datagrams checked
// against a datagram-level echo model.
module tb_udp_echo_ctrl;
  localparam int MAXL = 1472;

  logic clk = 1'b0;
  logic rst;

  udp_echo_if u_if ();

  udp_echo_ctrl #(
    .ADDR_W (11),
    .MAX_LEN(MAXL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .u_if(u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int t_en = -1;
  int t_done = -1;
  int tx_got = 0;
  int exp_len = 0;
  int exp_drop = 0;
  int tx_idx = 0;
  logic [7:0] pay[$];
  logic [7:0] exp_q[$];
  bit echo_busy = 0;
  bit en_expect = 0;
  bit tx_active = 0;
  bit auto_req = 1;
  bit req_pend = 0;
  bit pend_real = 0;
  bit pend_last = 0;
  bit fall_pend = 0;
  logic [7:0] pend_byte = 8'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill(input int len);
    pay.delete();
    for (int i = 0; i < len; i++)
      pay.push_back(8'($urandom));
  endtask

  // one clock: observe outputs, run the transmit sink
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!en_expect)
      chk("tx_en_spurious", 32'(u_if.udp_tx_en), 32'd0);
    if (u_if.udp_tx_en === 1'b1) begin
      en_cnt++;
      t_en = cyc;
      chk("tx_data_num", 32'(u_if.udp_tx_data_num),
          32'(exp_len));
      en_expect = 0;
      tx_active = 1;
      tx_idx = 0;
    end
    if (fall_pend) begin
      chk("busy_fall", 32'(u_if.busy), 32'd0);
      fall_pend = 0;
      echo_busy = 0;
    end
    if (req_pend) begin
      chk("tx_data", 32'(u_if.udp_tx_data),
          32'(pend_byte));
      if (pend_real) tx_got++;
      if (pend_last) begin
        chk("busy_last", 32'(u_if.busy), 32'd1);
        fall_pend = 1;
      end
    end
    u_if.udp_tx_req = 1'b0;
    req_pend = 0;
    if (auto_req && tx_active) begin
      u_if.udp_tx_req = 1'b1;
      req_pend = 1;
      if (tx_idx < exp_len) begin
        pend_byte = exp_q[tx_idx];
        pend_real = 1;
        pend_last = (tx_idx == exp_len - 1);
        tx_idx++;
      end else begin
        pend_byte = 8'd0;
        pend_real = 0;
        pend_last = 0;
        tx_active = 0;
      end
    end
  endtask

  // datagram-level accept/drop rule
  task automatic judge(input int len, input int num,
                       input bit was_busy);
    if (!was_busy && len == num &&
        len >= 1 && len <= MAXL) begin
      exp_q = pay;
      exp_len = len;
      echo_busy = 1;
      en_expect = 1;
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  task automatic send_dgram(input int len, input int num);
    bit was_busy;
    was_busy = echo_busy;
    for (int i = 0; i < len; i++) begin
      u_if.udp_rx_data_vld = 1'b1;
      u_if.udp_rx_data = pay[i];
      u_if.udp_rx_done = (i == len - 1);
      u_if.udp_rx_data_num = (i == len - 1) ?
                             16'(num) : 16'($urandom);
      if (i == len - 1) begin
        t_done = cyc;
        judge(len, num, was_busy);
      end
      tick();
      if (i == 0 && len > 1 && !was_busy)
        chk("busy_recv", 32'(u_if.busy), 32'd1);
    end
    if (len == 0) begin
      u_if.udp_rx_data_vld = 1'b0;
      u_if.udp_rx_done = 1'b1;
      u_if.udp_rx_data_num = 16'(num);
      t_done = cyc;
      judge(len, num, was_busy);
      tick();
    end
    u_if.udp_rx_data_vld = 1'b0;
    u_if.udp_rx_done = 1'b0;
    u_if.udp_rx_data = 8'd0;
    chk("drop_cnt", 32'(u_if.drop_cnt), 32'(exp_drop));
    chk("busy_model", 32'(u_if.busy), 32'(echo_busy));
  endtask

  task automatic wait_echo();
    int n;
    n = 0;
    while (echo_busy && n < 4000) begin
      tick();
      n++;
    end
    chk("echo_done", 32'(echo_busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(u_if.udp_tx_en), 32'd0);
    chk({tag, "_data"}, 32'(u_if.udp_tx_data), 32'd0);
    chk({tag, "_num"}, 32'(u_if.udp_tx_data_num), 32'd0);
    chk({tag, "_busy"}, 32'(u_if.busy), 32'd0);
    chk({tag, "_drop"}, 32'(u_if.drop_cnt), 32'd0);
  endtask

  initial begin
    int base_en;
    int base_got;
    int t_rdy;
    int n;
    int len;
    int num;

    rst = 1'b1;
    u_if.udp_rx_data_vld = 1'b0;
    u_if.udp_rx_data = 8'd0;
    u_if.udp_rx_done = 1'b0;
    u_if.udp_rx_data_num = 16'd0;
    u_if.tx_rdy = 1'b1;
    u_if.udp_tx_req = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) tick();

    // basic 4-byte echo
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    base_got = tx_got;
    send_dgram(4, 4);
    wait_echo();
    chk("lat_done_en", 32'(t_en - t_done), 32'd2);
    chk("basic_en_cnt", 32'(en_cnt), 32'd1);
    chk("basic_bytes", 32'(tx_got - base_got), 32'd4);
    repeat (2) tick();

    // transmitter not ready for 50 cycles
    u_if.tx_rdy = 1'b0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    base_en = en_cnt;
    send_dgram(4, 4);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("tx_en_hold", 32'(u_if.udp_tx_en), 32'd0);
    end
    u_if.tx_rdy = 1'b1;
    t_rdy = cyc;
    tick();
    chk("lat_rdy_en", 32'(t_en - t_rdy), 32'd1);
    wait_echo();
    chk("rdy_en_once", 32'(en_cnt - base_en), 32'd1);
    repeat (2) tick();

    // length mismatch
    base_en = en_cnt;
    fill(5);
    send_dgram(5, 6);
    repeat (4) tick();
    chk("mism_no_en", 32'(en_cnt - base_en), 32'd0);
    chk("mism_idle", 32'(u_if.busy), 32'd0);

    // zero-length datagram
    fill(0);
    send_dgram(0, 0);
    repeat (2) tick();

    // oversize, then largest legal datagram
    fill(MAXL + 1);
    send_dgram(MAXL + 1, MAXL + 1);
    repeat (2) tick();
    chk("over_no_en", 32'(en_cnt - base_en), 32'd0);
    fill(MAXL);
    base_got = tx_got;
    send_dgram(MAXL, MAXL);
    wait_echo();
    chk("max_bytes", 32'(tx_got - base_got), 32'(MAXL));
    repeat (2) tick();

    // second datagram during a 64-byte echo
    fill(64);
    base_en = en_cnt;
    base_got = tx_got;
    send_dgram(64, 64);
    n = 0;
    while (tx_got < base_got + 5 && n < 200) begin
      tick();
      n++;
    end
    chk("ovl_started", 32'(tx_got - base_got >= 5),
        32'd1);
    fill(8);
    send_dgram(8, 8);
    wait_echo();
    repeat (3) tick();
    chk("ovl_bytes", 32'(tx_got - base_got), 32'd64);
    chk("ovl_en_once", 32'(en_cnt - base_en), 32'd1);
    chk("ovl_drop", 32'(u_if.drop_cnt), 32'(exp_drop));

    // random lengths, occasional mismatch, random ready delay
    for (int k = 0; k < 8; k++) begin
      len = int'($urandom_range(1, 100));
      num = ($urandom_range(0, 3) == 0) ? len + 1 : len;
      fill(len);
      base_got = tx_got;
      u_if.tx_rdy = 1'b0;
      send_dgram(len, num);
      repeat ($urandom_range(0, 5)) tick();
      u_if.tx_rdy = 1'b1;
      wait_echo();
      repeat (2) tick();
      chk("rand_bytes", 32'(tx_got - base_got),
          32'((num == len) ? len : 0));
    end

    // reset in the middle of a 20-byte echo
    fill(20);
    base_got = tx_got;
    send_dgram(20, 20);
    n = 0;
    while (tx_got < base_got + 10 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", 32'(tx_got - base_got),
        32'd10);
    auto_req = 0;
    u_if.udp_tx_req = 1'b0;
    req_pend = 0;
    pend_last = 0;
    tx_active = 0;
    rst = 1'b1;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    exp_drop = 0;
    echo_busy = 0;
    en_expect = 0;
    fall_pend = 0;
    auto_req = 1;
    base_en = en_cnt;
    repeat (8) tick();
    chk("rst_no_en", 32'(en_cnt - base_en), 32'd0);
    fill(3);
    base_got = tx_got;
    send_dgram(3, 3);
    wait_echo();
    chk("post_rst_bytes", 32'(tx_got - base_got), 32'd3);
    chk("post_rst_en", 32'(en_cnt - base_en), 32'd1);
    chk("post_rst_drop", 32'(u_if.drop_cnt), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
